eth_tx_rmii_framer: RTL and testbench

Transmit framer that sits directly downstream of the TX byte FIFO. On a start request it pulls a fixed number of payload bytes from the FIFO, wraps them in preamble/SFD, zero-pads to the 60-byte Ethernet minimum, appends the CRC-32 FCS, and serialises the frame as RMII dibits. It then enforces the 96-bit-time inter-frame gap. Clock is the 50 MHz RMII reference clock, so one byte occupies 4 cycles.

---
 rtl/eth_tx_rmii_framer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_eth_tx_rmii_framer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_rmii_framer.sv
// eth_tx_rmii_framer: pulls a fixed-length payload from the TX byte FIFO and
// sends it as an Ethernet frame over RMII. The frame is preamble, SFD,
// payload, zero pad up to MIN_LEN bytes, then the CRC-32 FCS. An inter-frame
// gap follows each frame. One byte takes four cycles on the 50 MHz reference
// clock.
module eth_tx_rmii_framer #(
  parameter int unsigned MAX_LEN   = 1514,
  parameter int unsigned MIN_LEN   = 60,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_start_i,
  input  logic [10:0] frame_len_i,
  output logic        fifo_rd_en_o,
  input  logic [7:0]  fifo_data_i,
  input  logic        fifo_empty_i,
  output logic [1:0]  eth_txd_o,
  output logic        eth_tx_en_o,
  output logic        busy_o,
  output logic        tx_done_o,
  output logic        underrun_o
);

  localparam int unsigned LEN_W     = 11;
  localparam int unsigned PRE_BYTES = 7;
  localparam int unsigned FCS_BYTES = 4;
  // The first IDLE cycle after the gap also carries Tx_En=0, so the IFG state
  // itself lasts one cycle less than the full gap. A start accepted in that
  // IDLE cycle gives exactly IFG_BYTES*4 idle cycles between frames.
  localparam int unsigned IFG_BUSY  = IFG_BYTES * 4 - 1;
  localparam logic [7:0]  PRE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE  = 8'hD5;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [LEN_W-1:0] cnt_q,   cnt_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [7:0]       byte_q,  byte_d;
  logic [31:0]      crc_q,   crc_d;
  logic             und_q,   und_d;
  logic [1:0]       txd_q,   txd_d;
  logic             tx_en_q, tx_en_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             urun_q,  urun_d;

  logic             accept_c;
  logic             slot_end_c;
  logic             data_last_c;
  logic             pad_needed_c;
  logic [31:0]      crc_next_c;

  // Reflected CRC-32 advanced by one byte, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                           input logic [7:0]  data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Decode helpers for the current slot
  always_comb begin
    accept_c     = tx_start_i && !busy_q && (frame_len_i != '0) &&
                   (frame_len_i <= LEN_W'(MAX_LEN));
    slot_end_c   = (phase_q == 2'd3);
    data_last_c  = (cnt_q == (len_q - LEN_W'(1)));
    pad_needed_c = (len_q < LEN_W'(MIN_LEN));
    crc_next_c   = crc_byte(crc_q, byte_q);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; all frame transitions happen on byte boundaries
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = S_PRE;
      end
      S_PRE: begin
        if (slot_end_c && (cnt_q == LEN_W'(PRE_BYTES - 1))) state_d = S_SFD;
      end
      S_SFD: begin
        if (slot_end_c) state_d = und_q ? S_IFG : S_DATA;
      end
      S_DATA: begin
        if (slot_end_c) begin
          if (und_q) begin
            state_d = S_IFG;
          end else if (data_last_c) begin
            state_d = pad_needed_c ? S_PAD : S_FCS;
          end
        end
      end
      S_PAD: begin
        if (slot_end_c && (cnt_q == LEN_W'(MIN_LEN - 1))) state_d = S_FCS;
      end
      S_FCS: begin
        if (slot_end_c && (cnt_q == LEN_W'(FCS_BYTES - 1))) state_d = S_IFG;
      end
      S_IFG: begin
        if (cnt_q == LEN_W'(IFG_BUSY - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and next values of the registered outputs
  always_comb begin
    phase_d = phase_q + 2'd1;
    cnt_d   = cnt_q;
    len_d   = len_q;
    byte_d  = byte_q;
    crc_d   = crc_q;
    und_d   = und_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    urun_d  = 1'b0;

    // A fetch that found the FIFO empty ends the frame at the next boundary
    if (rd_en_q && fifo_empty_i) begin
      urun_d = 1'b1;
      und_d  = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (accept_c) begin
          len_d  = frame_len_i;
          cnt_d  = '0;
          byte_d = PRE_BYTE;
          crc_d  = CRC_INIT;
          und_d  = 1'b0;
        end
      end
      S_PRE: begin
        if (slot_end_c) begin
          if (cnt_q == LEN_W'(PRE_BYTES - 1)) begin
            cnt_d  = '0;
            byte_d = SFD_BYTE;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      S_SFD: begin
        if (phase_q == 2'd0) rd_en_d = 1'b1;
        if (slot_end_c) begin
          cnt_d  = '0;
          byte_d = fifo_data_i;
        end
      end
      S_DATA: begin
        if ((phase_q == 2'd0) && !data_last_c && !und_q) rd_en_d = 1'b1;
        if (slot_end_c) begin
          crc_d = crc_next_c;
          if (!data_last_c) begin
            cnt_d  = cnt_q + LEN_W'(1);
            byte_d = fifo_data_i;
          end else if (pad_needed_c) begin
            cnt_d  = cnt_q + LEN_W'(1);
            byte_d = '0;
          end else begin
            cnt_d  = '0;
            byte_d = ~crc_next_c[7:0];
          end
        end
      end
      S_PAD: begin
        if (slot_end_c) begin
          crc_d = crc_next_c;
          if (cnt_q == LEN_W'(MIN_LEN - 1)) begin
            cnt_d  = '0;
            byte_d = ~crc_next_c[7:0];
          end else begin
            cnt_d  = cnt_q + LEN_W'(1);
            byte_d = '0;
          end
        end
      end
      S_FCS: begin
        if (slot_end_c) begin
          cnt_d = cnt_q + LEN_W'(1);
          case (cnt_q[1:0])
            2'd0:    byte_d = ~crc_q[15:8];
            2'd1:    byte_d = ~crc_q[23:16];
            2'd2:    byte_d = ~crc_q[31:24];
            default: byte_d = '0;
          endcase
        end
      end
      S_IFG: begin
        cnt_d = cnt_q + LEN_W'(1);
        if ((cnt_q == LEN_W'(IFG_BUSY - 2)) && !und_q) done_d = 1'b1;
      end
      default: begin
        phase_d = '0;
      end
    endcase

    if ((state_d == S_IFG) && (state_q != S_IFG)) cnt_d = '0;
  end

  // Output comb: line signals follow the state and byte being entered
  always_comb begin
    tx_en_d = (state_d == S_PRE) || (state_d == S_SFD) || (state_d == S_DATA) ||
              (state_d == S_PAD) || (state_d == S_FCS);
    busy_d  = (state_d != S_IDLE);
    txd_d   = tx_en_d ? byte_d[{phase_d, 1'b0} +: 2] : 2'b00;
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      byte_q  <= '0;
      crc_q   <= CRC_INIT;
      und_q   <= 1'b0;
      txd_q   <= 2'b00;
      tx_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      byte_q  <= byte_d;
      crc_q   <= crc_d;
      und_q   <= und_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
  end

  assign eth_txd_o    = txd_q;
  assign eth_tx_en_o  = tx_en_q;
  assign fifo_rd_en_o = rd_en_q;
  assign busy_o       = busy_q;
  assign tx_done_o    = done_q;
  assign underrun_o   = urun_q;

endmodule

// File: tb/tb_eth_tx_rmii_framer.sv
// Bench for eth_tx_rmii_framer. A FIFO model feeds the DUT. Each issued frame
// pushes its expected bytes and frame properties onto queues. A monitor
// decodes the RMII stream, then pops and compares at each frame end and again
// when Busy falls after the gap.
`timescale 1ns/1ps
module tb_eth_tx_rmii_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [10:0] frame_len = '0;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic [1:0]  eth_txd;
  logic        eth_tx_en;
  logic        busy;
  logic        tx_done;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  eth_tx_rmii_framer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tx_start_i   (tx_start),
    .frame_len_i  (frame_len),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_data_i  (fifo_data),
    .fifo_empty_i (fifo_empty),
    .eth_txd_o    (eth_txd),
    .eth_tx_en_o  (eth_tx_en),
    .busy_o       (busy),
    .tx_done_o    (tx_done),
    .underrun_o   (underrun)
  );

  // FIFO model with registered read data
  logic [7:0] mem [0:4095];
  int         wp = 0;
  int         rp = 0;
  logic       fifo_flush = 1'b0;
  assign fifo_empty = (rp == wp);

  always @(posedge clk) begin
    if (rst) fifo_data <= 8'h00;
    if (fifo_flush) rp <= wp;
    else if (fifo_rd_en && (rp != wp)) begin
      fifo_data <= mem[rp];
      rp <= rp + 1;
    end
  end

  typedef struct {
    int nbytes;
    int cycles;
    int reads;
    bit urun;
    int gap;
  } desc_t;

  desc_t       dq[$];
  logic [7:0]  eq[$];
  logic [31:0] crc_tab [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_tab_upd(input logic [31:0] c, input logic [7:0] b);
    return crc_tab[c[7:0] ^ b] ^ (c >> 8);
  endfunction

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int j = 0; j < 8; j++) begin
      if (r[0] ^ b[j]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic load(input int n, input int start, input int step);
    for (int i = 0; i < n; i++) begin
      mem[wp] = 8'(start + i * step);
      wp++;
    end
  endtask

  // Push the expected frame, then pulse Tx_Start. Call right after a posedge.
  task automatic issue(input int len, input int exp_cycles, input int gap);
    desc_t d;
    int base;
    int avail;
    int n;
    logic [31:0] c;
    base  = rp;
    avail = wp - base;
    d.urun = (avail < len);
    n = d.urun ? avail : len;
    for (int i = 0; i < 7; i++) eq.push_back(8'h55);
    eq.push_back(8'hD5);
    for (int i = 0; i < n; i++) eq.push_back(mem[base + i]);
    if (!d.urun) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len; i++) c = crc_tab_upd(c, mem[base + i]);
      for (int i = len; i < 60; i++) begin
        eq.push_back(8'h00);
        c = crc_tab_upd(c, 8'h00);
      end
      c = ~c;
      eq.push_back(c[7:0]);
      eq.push_back(c[15:8]);
      eq.push_back(c[23:16]);
      eq.push_back(c[31:24]);
      d.nbytes = 12 + ((len < 60) ? 60 : len);
      d.reads  = len;
    end else begin
      d.nbytes = 8 + n;
      d.reads  = n + 1;
    end
    d.cycles = exp_cycles;
    d.gap    = gap;
    dq.push_back(d);
    #1;
    frame_len = 11'(len);
    tx_start  = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
  endtask

  // Monitor state
  int         hi_cnt = 0, lo_cnt = 0, rd_cnt = 0, stray_rd = 0, dib_n = 0;
  int         frames = 0, done_cnt = 0, urun_cnt = 0, done_idx = 0, last_gap = 0;
  logic [7:0] cur = '0;
  logic [7:0] cap[$];
  logic       prev_en = 1'b0;
  bit         ifg_track = 1'b0;
  desc_t      cd;

  task automatic frame_end();
    int mism;
    int first_bad;
    int pre_bad;
    logic [7:0] e;
    logic [31:0] r;
    frames++;
    if (dq.size() == 0) begin
      check("unexpected_frame", 32'(frames), 32'(0));
      return;
    end
    cd = dq.pop_front();
    check("tx_en_cycles", 32'(hi_cnt), 32'(cd.cycles));
    check("byte_count", 32'(cap.size()), 32'(cd.nbytes));
    check("fifo_reads", 32'(rd_cnt), 32'(cd.reads));
    pre_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= cap.size()) pre_bad++;
      else if (cap[i] !== ((i == 7) ? 8'hD5 : 8'h55)) pre_bad++;
    end
    check("preamble_sfd", 32'(pre_bad), 32'(0));
    mism = 0;
    first_bad = -1;
    for (int i = 0; i < cd.nbytes; i++) begin
      e = eq.pop_front();
      if ((i >= cap.size()) || (cap[i] !== e)) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (mism != 0) $display("  first differing byte index %0d", first_bad);
    check("frame_bytes", 32'(mism), 32'(0));
    if (!cd.urun && (cap.size() >= 12)) begin
      r = 32'hFFFFFFFF;
      for (int i = 8; i < cap.size(); i++) r = crc_bit(r, cap[i]);
      check("crc_residue", r, 32'hDEBB20E3);
    end
    if (cd.gap >= 0) check("interframe_gap", 32'(last_gap), 32'(cd.gap));
    ifg_track = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en   = 1'b0;
        ifg_track = 1'b0;
        cap.delete();
        hi_cnt = 0;
        dib_n  = 0;
        rd_cnt = 0;
      end else begin
        if (eth_tx_en) begin
          if (!prev_en) begin
            last_gap = lo_cnt;
            hi_cnt = 0; dib_n = 0; rd_cnt = 0;
            urun_cnt = 0; done_cnt = 0;
            cap.delete();
          end
          hi_cnt++;
          cur = {eth_txd, cur[7:2]};
          dib_n++;
          if (dib_n == 4) begin
            cap.push_back(cur);
            dib_n = 0;
          end
          if (fifo_rd_en) rd_cnt++;
          if (tx_done) done_cnt++;
          if (underrun) urun_cnt++;
        end else begin
          if (fifo_rd_en) stray_rd++;
          if (prev_en) begin
            lo_cnt = 0;
            frame_end();
          end
          lo_cnt++;
          if (underrun) urun_cnt++;
          if (tx_done) begin
            done_cnt++;
            done_idx = lo_cnt;
          end
          if (ifg_track && !busy) begin
            ifg_track = 1'b0;
            check("low_cycles_to_busy_fall", 32'(lo_cnt), 32'(48));
            check("tx_done_count", 32'(done_cnt), cd.urun ? 32'(0) : 32'(1));
            if (!cd.urun) check("tx_done_position", 32'(done_idx), 32'(47));
            check("underrun_count", 32'(urun_cnt), cd.urun ? 32'(1) : 32'(0));
          end
        end
        prev_en = eth_tx_en;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || (dq.size() != 0) || ifg_track) && (n < budget));
    check("idle_reached", (n < budget) ? 32'(1) : 32'(0), 32'(1));
    @(posedge clk);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && (n < budget));
    check("tx_done_seen", (n < budget) ? 32'(1) : 32'(0), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int act;
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? (32'hEDB88320 ^ (c >> 1)) : (c >> 1);
      crc_tab[n] = c;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 32'(eth_txd), 32'(0));
    check("rst_tx_en", 32'(eth_tx_en), 32'(0));
    check("rst_rd_en", 32'(fifo_rd_en), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_tx_done", 32'(tx_done), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);

    // 60-byte frame of 0x00..0x3B
    load(60, 0, 1);
    issue(60, 288, -1);
    wait_idle(1000);

    // Header-only frame, padded; a Tx_Start while busy must be ignored
    load(14, 8'hA0, 3);
    issue(14, 288, -1);
    repeat (60) @(posedge clk);
    #1 frame_len = 11'd60; tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    wait_idle(1000);

    // Out-of-range lengths while idle
    #1 frame_len = 11'd0; tx_start = 1'b1;
    @(posedge clk);
    #1 frame_len = 11'd1515;
    @(posedge clk);
    #1 tx_start = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eth_tx_en || busy || fifo_rd_en || (eth_txd != 2'b00)) act++;
    end
    check("ignored_start_activity", 32'(act), 32'(0));
    @(posedge clk);

    // Maximum frames back to back
    load(3028, 5, 7);
    issue(1514, 6104, -1);
    wait_done(7000);
    @(posedge clk);
    issue(1514, 6104, 48);
    wait_idle(7000);

    // Underrun: only 20 bytes available
    load(20, 8'h11, 13);
    issue(60, 112, -1);
    wait_idle(1000);

    // Reset in the middle of a 100-byte frame
    load(100, 8'h40, 1);
    #1 frame_len = 11'd100; tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx_en", 32'(eth_tx_en), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_txd", 32'(eth_txd), 32'(0));
    check("midrst_rd_en", 32'(fifo_rd_en), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0; fifo_flush = 1'b1;
    @(posedge clk);
    #1 fifo_flush = 1'b0;
    @(posedge clk);
    load(64, 8'hC3, 5);
    issue(64, 304, -1);
    wait_idle(1000);

    check("stray_reads", 32'(stray_rd), 32'(0));
    check("pending_frames", 32'(dq.size()), 32'(0));
    check("frames_seen", 32'(frames), 32'(6));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
